arbitro_memoria_dados: RTL and testbench
========================================

Name: arbitro_memoria_dados

Overview:
- Shares the single-port data memory (32-bit word address, synchronous write, combinational read) between two requesters: the CPU datapath (port cpu_) and an I/O/loader port (port es_).
- The CPU has fixed priority. A wait counter forces a grant to the I/O port after it has waited MAX_ESPERA cycles, so it is never starved.
- Sits between the MEM stage / I/O controller and the data memory. It drives the memory's endereco, memWrite and dado_Escrito, and registers dado_Lido back to the granted requester.

Parameters:
- MEM_SIZE, 150, number of memory words; addresses >= MEM_SIZE are out of range.
- MAX_ESPERA, 4, cycles the I/O port may wait with es_req high before it is forced ahead of the CPU (legal 1..15).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- cpu_req  input  1  CPU access request.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_endereco  input  32  CPU word address.
- cpu_dado  input  32  CPU write data.
- cpu_grant  output  1  combinational; the CPU request is accepted this cycle.
- cpu_valido  output  1  registered; cpu_lido is valid this cycle.
- cpu_lido  output  32  registered read data for the CPU.
- es_req, es_we, es_endereco[31:0], es_dado[31:0]  input  same meanings for the I/O port.
- es_grant, es_valido, es_lido[31:0]  output  same meanings for the I/O port.
- erro_endereco  output  1  registered; pulses 1 cycle after an out-of-range access is granted.
- mem_endereco  output  32  to memory address.
- mem_memWrite  output  1  to memory write enable.
- mem_dado_Escrito  output  32  to memory write data.
- mem_dado_Lido  input  32  from memory combinational read data.

Behaviour:
- Reset: all registered outputs are 0 (cpu_valido, es_valido, cpu_lido, es_lido, erro_endereco). The wait counter is 0. The grant owner register holds NENHUM.
- Handshake: a requester holds req, we, endereco and dado stable until it sees its grant. Dropping req before the grant is legal (request withdrawn). Grant lasts one cycle per access; a held req after a grant is a new access.
- Arbitration (combinational, each cycle):
  - If es_req and cnt_espera >= MAX_ESPERA: grant es.
  - Else if cpu_req: grant cpu.
  - Else if es_req: grant es.
  - Else: no grant.
- At most one grant per cycle.
- Memory drive:
  - Granted port's endereco and dado go to mem_endereco and mem_dado_Escrito.
  - mem_memWrite = granted we AND endereco < MEM_SIZE.
  - With no grant: mem_memWrite = 0, mem_endereco = 0, mem_dado_Escrito = 0.
- Wait counter:
  - Increments (saturating at 15) each cycle es_req is high and es_grant is low.
  - Clears to 0 on es_grant or when es_req is low.
- Response, latency 1 cycle after the grant:
  - On the posedge ending a grant cycle, the granted port's valido goes to 1 for exactly one cycle.
  - For a read, lido <= mem_dado_Lido, or 0 if out of range.
  - For a write, lido keeps its old value; valido still pulses as the write acknowledge.
  - Non-granted port's valido = 0.
- Out of range (endereco >= MEM_SIZE):
  - Write is suppressed.
  - Read returns 0.
  - erro_endereco = 1 in the valido cycle.
  - valido still pulses so the requester never hangs.
- Back-to-back: a grant is allowed in the same cycle as the previous valido, giving a throughput of 1 access/cycle.
- Simultaneous requests at the same address: the higher-priority port is served first. The other port's next access sees the updated data.
- Reset mid-operation:
  - A write granted in the reset cycle is not performed (mem_memWrite forced 0 while reset).
  - Pending valido/lido clear.
  - Wait counter clears.
  - No grants are issued while reset is high.

Test Plan:
- CPU only: cpu write 0xDEADBEEF @10, next cycle cpu read @10 -> cpu_grant both cycles; cpu_valido 1 cycle after each; cpu_lido = 0xDEADBEEF after the read.
- Contention: cpu_req and es_req held for 10 cycles, MAX_ESPERA=4 -> CPU granted cycles 0-3, es granted cycle 4, CPU cycles 5-8, es cycle 9. Wait counter returns to 0 after each es grant.
- Address bounds: es write 0x12345678 @149 then read @149 -> data returned, erro_endereco=0. es write @150 -> mem_memWrite=0, es_valido=1, erro_endereco=1; subsequent read @150 returns 0.
- Same-address race: cpu write 0x1 and es read both @20 in the same cycle -> CPU first; es read one cycle later returns 0x1.
- Reset mid-operation: assert reset in a cpu write @5 (0xAAAA) grant cycle -> mem_memWrite=0; after reset, read @5 does not return 0xAAAA; all valido = 0 during reset.
- Withdrawal: es_req high 2 cycles (blocked by CPU), then dropped -> no es_grant, no es_valido, counter back to 0.

Source files
------------

// File: rtl/arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_memoria_dados
// Description : Two-port arbiter (CPU fixed priority, I/O anti-starvation)
//               in front of a single-port data memory; 1-cycle responses.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_memoria_dados #(
    parameter int MEM_SIZE   = 150,
    parameter int MAX_ESPERA = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_endereco,
    input  logic [31:0] cpu_dado,
    output logic        cpu_grant,
    output logic        cpu_valido,
    output logic [31:0] cpu_lido,
    input  logic        es_req,
    input  logic        es_we,
    input  logic [31:0] es_endereco,
    input  logic [31:0] es_dado,
    output logic        es_grant,
    output logic        es_valido,
    output logic [31:0] es_lido,
    output logic        erro_endereco,
    output logic [31:0] mem_endereco,
    output logic        mem_memWrite,
    output logic [31:0] mem_dado_Escrito,
    input  logic [31:0] mem_dado_Lido
);

    // One-hot owner encoding so each valido is a direct flop output.
    typedef enum logic [1:0] {
        NENHUM   = 2'b00,
        DONO_CPU = 2'b01,
        DONO_ES  = 2'b10
    } dono_t;

    localparam logic [3:0]  C_CNT_MAX  = 4'd15;
    localparam logic [3:0]  C_LIMITE   = 4'(MAX_ESPERA);
    localparam logic [31:0] C_MEM_SIZE = 32'(MEM_SIZE);

    dono_t       r_dono;
    logic [3:0]  r_cnt_espera;
    logic [31:0] r_cpu_lido;
    logic [31:0] r_es_lido;
    logic        r_erro;

    logic        w_grant_cpu;
    logic        w_grant_es;
    logic        w_we;
    logic        w_fora;
    logic [31:0] w_endereco;
    logic [31:0] w_dado;

    always_comb begin
        w_grant_es  = 1'b0;
        w_grant_cpu = 1'b0;
        w_we        = 1'b0;
        w_endereco  = 32'd0;
        w_dado      = 32'd0;
        if (!reset) begin
            w_grant_es  = es_req && ((r_cnt_espera >= C_LIMITE) || !cpu_req);
            w_grant_cpu = cpu_req && !w_grant_es;
        end
        if (w_grant_cpu) begin
            w_we       = cpu_we;
            w_endereco = cpu_endereco;
            w_dado     = cpu_dado;
        end else if (w_grant_es) begin
            w_we       = es_we;
            w_endereco = es_endereco;
            w_dado     = es_dado;
        end
        w_fora = (w_endereco >= C_MEM_SIZE);
    end

    assign cpu_grant        = w_grant_cpu;
    assign es_grant         = w_grant_es;
    assign mem_endereco     = w_endereco;
    assign mem_dado_Escrito = w_dado;
    // Grants are already blocked during reset, so this also kills writes then.
    assign mem_memWrite     = w_we && !w_fora;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dono       <= NENHUM;
            r_cnt_espera <= 4'd0;
            r_cpu_lido   <= 32'd0;
            r_es_lido    <= 32'd0;
            r_erro       <= 1'b0;
        end else begin
            if (w_grant_cpu) begin
                r_dono <= DONO_CPU;
            end else if (w_grant_es) begin
                r_dono <= DONO_ES;
            end else begin
                r_dono <= NENHUM;
            end

            r_erro <= (w_grant_cpu || w_grant_es) && w_fora;

            if (w_grant_cpu && !w_we) begin
                r_cpu_lido <= w_fora ? 32'd0 : mem_dado_Lido;
            end
            if (w_grant_es && !w_we) begin
                r_es_lido <= w_fora ? 32'd0 : mem_dado_Lido;
            end

            if (es_req && !w_grant_es) begin
                if (r_cnt_espera != C_CNT_MAX) begin
                    r_cnt_espera <= r_cnt_espera + 4'd1;
                end
            end else begin
                r_cnt_espera <= 4'd0;
            end
        end
    end

    assign cpu_valido    = r_dono[0];
    assign es_valido     = r_dono[1];
    assign cpu_lido      = r_cpu_lido;
    assign es_lido       = r_es_lido;
    assign erro_endereco = r_erro;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_memoria_dados.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_memoria_dados
// Description : Directed scoreboard bench for arbitro_memoria_dados.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_memoria_dados;

    localparam int MEM_SIZE   = 150;
    localparam int MAX_ESPERA = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, es_req, es_we;
    logic [31:0] cpu_endereco, cpu_dado, es_endereco, es_dado;
    logic        cpu_grant, cpu_valido, es_grant, es_valido, erro_endereco;
    logic [31:0] cpu_lido, es_lido;
    logic [31:0] mem_endereco, mem_dado_Escrito, mem_dado_Lido;
    logic        mem_memWrite;
    logic        limpa_mem;

    typedef struct {
        logic [31:0] lido;
        logic        erro;
    } resp_t;

    resp_t       q_cpu[$];
    resp_t       q_es[$];
    logic [31:0] mem [0:255];
    logic [31:0] modelo [0:255];
    logic [31:0] exp_cpu_lido;
    logic [31:0] exp_es_lido;
    int          checks = 0;
    int          erros  = 0;

    always #5 clock = ~clock;

    arbitro_memoria_dados #(
        .MEM_SIZE   (MEM_SIZE),
        .MAX_ESPERA (MAX_ESPERA)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .cpu_endereco     (cpu_endereco),
        .cpu_dado         (cpu_dado),
        .cpu_grant        (cpu_grant),
        .cpu_valido       (cpu_valido),
        .cpu_lido         (cpu_lido),
        .es_req           (es_req),
        .es_we            (es_we),
        .es_endereco      (es_endereco),
        .es_dado          (es_dado),
        .es_grant         (es_grant),
        .es_valido        (es_valido),
        .es_lido          (es_lido),
        .erro_endereco    (erro_endereco),
        .mem_endereco     (mem_endereco),
        .mem_memWrite     (mem_memWrite),
        .mem_dado_Escrito (mem_dado_Escrito),
        .mem_dado_Lido    (mem_dado_Lido)
    );

    // Memory model: synchronous write, combinational read.
    always @(posedge clock) begin
        if (limpa_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (mem_memWrite) begin
            mem[mem_endereco[7:0]] <= mem_dado_Escrito;
        end
    end
    assign mem_dado_Lido = (mem_endereco < 32'd256) ? mem[mem_endereco[7:0]] : 32'hBADBAD00;

    function automatic void chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            erros++;
            $display("FAIL %s got %h expected %h", nome, got, exp);
        end
    endfunction

    // Predicts the response of one expected grant and queues it.
    task automatic esperar_resp(input logic porta_es, input logic we,
                                input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        logic  fora;
        fora = (a >= 32'(MEM_SIZE));
        if (we) begin
            if (!fora) modelo[a[7:0]] = d;
        end else if (porta_es) begin
            exp_es_lido = fora ? 32'd0 : modelo[a[7:0]];
        end else begin
            exp_cpu_lido = fora ? 32'd0 : modelo[a[7:0]];
        end
        r.lido = porta_es ? exp_es_lido : exp_cpu_lido;
        r.erro = fora;
        if (porta_es) q_es.push_back(r);
        else          q_cpu.push_back(r);
    endtask

    task automatic ciclo(input string nome, input logic rs,
                         input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                         input logic egc, input logic ege);
        logic emw;
        @(negedge clock);
        reset = rs;
        cpu_req = cr; cpu_we = cw; cpu_endereco = ca; cpu_dado = cd;
        es_req = er;  es_we = ew;  es_endereco = ea;  es_dado = ed;
        #1;
        emw = (egc && cw && ca < 32'(MEM_SIZE)) || (ege && ew && ea < 32'(MEM_SIZE));
        chk({nome, "_cpu_grant"}, {31'd0, cpu_grant}, {31'd0, egc});
        chk({nome, "_es_grant"}, {31'd0, es_grant}, {31'd0, ege});
        chk({nome, "_memWrite"}, {31'd0, mem_memWrite}, {31'd0, emw});
        if (egc) esperar_resp(1'b0, cw, ca, cd);
        if (ege) esperar_resp(1'b1, ew, ea, ed);
    endtask

    task automatic ocioso(input string nome);
        ciclo(nome, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever a port presents valido.
    always @(negedge clock) begin
        resp_t r;
        if (cpu_valido === 1'b1) begin
            if (q_cpu.size() == 0) begin
                chk("cpu_valido_unexpected", 32'd1, 32'd0);
            end else begin
                r = q_cpu.pop_front();
                chk("cpu_lido", cpu_lido, r.lido);
                chk("cpu_erro", {31'd0, erro_endereco}, {31'd0, r.erro});
            end
        end
        if (es_valido === 1'b1) begin
            if (q_es.size() == 0) begin
                chk("es_valido_unexpected", 32'd1, 32'd0);
            end else begin
                r = q_es.pop_front();
                chk("es_lido", es_lido, r.lido);
                chk("es_erro", {31'd0, erro_endereco}, {31'd0, r.erro});
            end
        end
        if (cpu_valido === 1'b0 && es_valido === 1'b0 && reset === 1'b0) begin
            chk("erro_idle", {31'd0, erro_endereco}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1; limpa_mem = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_endereco = 32'd0; cpu_dado = 32'd0;
        es_req = 1'b0;  es_we = 1'b0;  es_endereco = 32'd0;  es_dado = 32'd0;
        exp_cpu_lido = 32'd0; exp_es_lido = 32'd0;
        for (int i = 0; i < 256; i++) modelo[i] = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; limpa_mem = 1'b0;
        #1;
        chk("rst_cpu_valido", {31'd0, cpu_valido}, 32'd0);
        chk("rst_es_valido", {31'd0, es_valido}, 32'd0);
        chk("rst_cpu_lido", cpu_lido, 32'd0);
        chk("rst_es_lido", es_lido, 32'd0);
        chk("rst_erro", {31'd0, erro_endereco}, 32'd0);

        // CPU only: write then read back
        ciclo("cpu_wr", 0, 1, 1, 32'd10, 32'hDEADBEEF, 0, 0, 0, 0, 1, 0);
        ciclo("cpu_rd", 0, 1, 0, 32'd10, 32'd0, 0, 0, 0, 0, 1, 0);
        ocioso("idle0");

        // Contention: I/O forced ahead after MAX_ESPERA blocked cycles
        for (int i = 0; i < 10; i++) begin
            ciclo($sformatf("cont%0d", i), 0, 1, 0, 32'd10, 32'd0, 1, 0, 32'd10, 32'd0,
                  (i != 4 && i != 9), (i == 4 || i == 9));
        end
        ocioso("idle1");

        // Address bounds
        ciclo("es_wr149", 0, 0, 0, 0, 0, 1, 1, 32'd149, 32'h12345678, 0, 1);
        ciclo("es_rd149", 0, 0, 0, 0, 0, 1, 0, 32'd149, 32'd0, 0, 1);
        ciclo("es_wr150", 0, 0, 0, 0, 0, 1, 1, 32'd150, 32'hCAFEF00D, 0, 1);
        ciclo("es_rd150", 0, 0, 0, 0, 0, 1, 0, 32'd150, 32'd0, 0, 1);
        ciclo("cpu_wr999", 0, 1, 1, 32'd999, 32'h55555555, 0, 0, 0, 0, 1, 0);
        ocioso("idle2");

        // Same-address race
        ciclo("race_a", 0, 1, 1, 32'd20, 32'h1, 1, 0, 32'd20, 32'd0, 1, 0);
        ciclo("race_b", 0, 0, 0, 0, 0, 1, 0, 32'd20, 32'd0, 0, 1);
        ocioso("idle3");

        // Withdrawal, then a fresh wait must start from zero
        ciclo("wd0", 0, 1, 0, 32'd149, 32'd0, 1, 0, 32'd20, 32'd0, 1, 0);
        ciclo("wd1", 0, 1, 0, 32'd149, 32'd0, 1, 0, 32'd20, 32'd0, 1, 0);
        ciclo("wd2", 0, 1, 0, 32'd149, 32'd0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            ciclo($sformatf("post_wd%0d", i), 0, 1, 0, 32'd10, 32'd0, 1, 0, 32'd149, 32'd0,
                  (i != 4), (i == 4));
        end
        ocioso("idle4");

        // Reset during a CPU write grant cycle
        ciclo("rst_wr", 1, 1, 1, 32'd5, 32'h0000AAAA, 0, 0, 0, 0, 0, 0);
        ciclo("rst_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_cpu_lido = 32'd0; exp_es_lido = 32'd0;
        ciclo("rst_rd5", 0, 1, 0, 32'd5, 32'd0, 0, 0, 0, 0, 1, 0);

        repeat (3) ocioso("tail");
        chk("q_cpu_empty", 32'(q_cpu.size()), 32'd0);
        chk("q_es_empty", 32'(q_es.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, erros);
        $finish;
    end

endmodule
`default_nettype wire
